raster_pixel_writer: RTL
========================

# raster_pixel_writer

Pixel sink on the output side of the edge rasterizer. Accepts the rasterizer's pixel stream (x, y, 2-bit depth, 16-bit ARGB color) through a valid/ready handshake, culls off-screen pixels, performs a read-modify-write depth test against the frame buffer's depth plane, and writes passing pixels. It also clears the frame buffer on command and turns the rasterizer's done level into a single frame-done pulse once the last accepted pixel has retired.

## Interface
- FB_WIDTH, 160, frame buffer width in pixels
- FB_HEIGHT, 120, frame buffer height in pixels
- ADDR_W, 15, memory address width; FB_WIDTH*FB_HEIGHT must be <= 2^ADDR_W
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_sig_clear  in  1  clear request, sampled only in IDLE
- in_clear_color  in  16  color written during clear
- in_pixel_valid  in  1  pixel presented
- out_pixel_ready  out  1  writer can accept a pixel
- in_pixel_x, in_pixel_y  in  16 each  screen coordinates
- in_pixel_depth  in  2  depth, 0 = nearest
- in_pixel_color  in  16  ARGB color
- in_sig_rasterize_done  in  1  rasterizer done level
- out_sig_frame_done  out  1  one-cycle pulse, frame retired
- out_mem_addr  out  ADDR_W  frame buffer address
- out_mem_rd_en  out  1  depth read strobe
- in_mem_depth_rdata  in  2  stored depth, valid one cycle after out_mem_rd_en
- out_mem_wr_en  out  1  write strobe, depth and color written together
- out_mem_wr_depth  out  2  depth write data
- out_mem_wr_color  out  16  color write data
- out_busy  out  1  high in any state other than IDLE
- out_pixels_written  out  16  count of pixels written, saturating
- out_pixels_culled  out  16  count of pixels off-screen or failing depth, saturating

## Operation
- States: IDLE, CLEAR, READ, TEST.
- IDLE:
  - out_pixel_ready = !in_sig_clear.
  - If in_sig_clear is high, go to CLEAR, zero both counters, and set the clear address to 0. Clear has priority; no pixel is accepted that cycle.
  - On accept (valid & ready) with x >= FB_WIDTH or y >= FB_HEIGHT: increment culled, stay in IDLE, issue no memory access.
  - On any other accept: register x, y, depth, color, and addr = y*FB_WIDTH + x, truncated to ADDR_W. Go to READ.
- READ: out_mem_rd_en = 1 and out_mem_addr = the registered addr. Go to TEST.
- TEST: compare in_pixel_depth <= in_mem_depth_rdata.
  - Pass: out_mem_wr_en = 1 with the registered addr, depth, and color; increment written.
  - Fail: increment culled.
  - Go to IDLE in both cases.
- CLEAR: out_mem_wr_en = 1 every cycle, out_mem_wr_depth = 2'b11 (DEPTH_FAR), out_mem_wr_color = in_clear_color, address counting 0 to FB_WIDTH*FB_HEIGHT-1. After the last address, go to IDLE.
- Frame done:
  - A rising edge of in_sig_rasterize_done, registered internally, sets a pending flag.
  - out_sig_frame_done pulses for one cycle in the first IDLE cycle with pending set, and that cycle clears pending.
  - A rising edge in the same cycle as the pulse re-sets pending.
- Counters saturate at 16'hFFFF.
- Memory strobes are never asserted simultaneously.
- The address arithmetic is an unsigned multiply-add. Coordinates are range-checked before the address is formed, so there is no wrap.

## Timing
- Reset: state IDLE, pending 0, counters 0, all strobes 0, out_mem_addr 0, write data 0, out_busy 0, out_sig_frame_done 0, out_pixel_ready 1.
- Pixel accepted in cycle T: out_mem_rd_en in T+1, depth sampled and optional write in T+2, out_pixel_ready high again in T+3. Throughput is one on-screen pixel per 3 cycles.
- Off-screen pixels are accepted back-to-back, one per cycle.
- Clear requested in cycle T: writes occur in T+1 through T+FB_WIDTH*FB_HEIGHT, and IDLE is reached in the following cycle.
- in_sig_clear outside IDLE is ignored.
- Reset asserted mid-pixel or mid-clear aborts at the next edge. Frame buffer contents are then undefined, and no partial write is issued after reset.

## Structure
- Shared package raster_pkg holds:
  - DEPTH_W = 2, COLOR_W = 16, COORD_W = 16
  - DEPTH_FAR = 2'b11
  - the state encoding
- Sub-module fb_addr_gen: a combinational y*FB_WIDTH + x with the bounds check, producing addr and an on_screen flag. It is reused later by the scan-out reader.

## Test plan
- Reset, then clear with in_clear_color = 16'h0000. Expect 19200 writes of depth 3 and color 0, out_busy high for 19200 cycles, and counters 0.
- Pixel (100,25), depth 0, color 16'hFF00, after clear. Expect rd_en at addr 4100, wr_en one cycle later with addr 4100, depth 0, color FF00, and written = 1.
- Same pixel again with depth 1. Expect a read, no write, and culled = 1. Then the same pixel with depth 0 and color 16'h00FF: expect a write (equal depth passes).
- Pixel (160,10), then (10,120), each with valid held. Expect both accepted on consecutive cycles, no memory strobes, and culled += 2.
- in_sig_rasterize_done rises in READ. Expect out_sig_frame_done for exactly one cycle, in the IDLE cycle after TEST.
- Assert reset_n low for one cycle in mid-clear at address 500. Expect no writes after reset, all outputs at reset values, and a new clear restarting at address 0.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared definitions for the raster pixel path.
// Holds pixel field widths, the far-plane depth written on clear, the writer
// state encoding and a saturating-counter helper shared by the writer.
package raster_pkg;

    localparam int DEPTH_W = 2;
    localparam int COLOR_W = 16;
    localparam int COORD_W = 16;

    localparam logic [DEPTH_W-1:0] DEPTH_FAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READ  = 2'd2,
        ST_TEST  = 2'd3
    } state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/raster_pixel_writer_if.sv
// Bundle of the pixel writer's signals: clear request, pixel stream
// handshake, frame-done level/pulse, frame buffer memory port and status.
// slave  : the pixel writer (consumes pixels, drives the memory port).
// master : the environment (rasterizer + frame buffer + control).
interface raster_pixel_writer_if #(
    parameter int ADDR_W = 15
);
    import raster_pkg::*;

    logic                in_sig_clear;
    logic [COLOR_W-1:0]  in_clear_color;
    logic                in_pixel_valid;
    logic                out_pixel_ready;
    logic [COORD_W-1:0]  in_pixel_x;
    logic [COORD_W-1:0]  in_pixel_y;
    logic [DEPTH_W-1:0]  in_pixel_depth;
    logic [COLOR_W-1:0]  in_pixel_color;
    logic                in_sig_rasterize_done;
    logic                out_sig_frame_done;
    logic [ADDR_W-1:0]   out_mem_addr;
    logic                out_mem_rd_en;
    logic [DEPTH_W-1:0]  in_mem_depth_rdata;
    logic                out_mem_wr_en;
    logic [DEPTH_W-1:0]  out_mem_wr_depth;
    logic [COLOR_W-1:0]  out_mem_wr_color;
    logic                out_busy;
    logic [15:0]         out_pixels_written;
    logic [15:0]         out_pixels_culled;

    modport slave (
        input  in_sig_clear, in_clear_color, in_pixel_valid, in_pixel_x,
               in_pixel_y, in_pixel_depth, in_pixel_color,
               in_sig_rasterize_done, in_mem_depth_rdata,
        output out_pixel_ready, out_sig_frame_done, out_mem_addr,
               out_mem_rd_en, out_mem_wr_en, out_mem_wr_depth,
               out_mem_wr_color, out_busy, out_pixels_written,
               out_pixels_culled
    );

    modport master (
        output in_sig_clear, in_clear_color, in_pixel_valid, in_pixel_x,
               in_pixel_y, in_pixel_depth, in_pixel_color,
               in_sig_rasterize_done, in_mem_depth_rdata,
        input  out_pixel_ready, out_sig_frame_done, out_mem_addr,
               out_mem_rd_en, out_mem_wr_en, out_mem_wr_depth,
               out_mem_wr_color, out_busy, out_pixels_written,
               out_pixels_culled
    );

endinterface

// File: rtl/fb_addr_gen.sv
// Combinational frame buffer address generator.
// Ports: x, y (screen coordinates) -> addr = y*FB_WIDTH + x and on_screen,
// which is high when the coordinate lies inside the frame buffer. addr is
// only meaningful when on_screen is high, so the truncated multiply-add
// never wraps for the coordinates that are actually used.
module fb_addr_gen
    import raster_pkg::*;
#(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int ADDR_W    = 15
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               on_screen
);

    assign on_screen = (x < COORD_W'(FB_WIDTH)) && (y < COORD_W'(FB_HEIGHT));
    assign addr      = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);

endmodule

// File: rtl/raster_pixel_writer.sv
// Pixel sink behind the edge rasterizer.
// Ports: clock, reset_n (synchronous, active-low) and the slave side of
// raster_pixel_writer_if. Accepts pixels, culls off-screen ones, does a
// read-modify-write depth test (smaller depth is nearer, ties pass), writes
// passing pixels, clears the whole frame buffer on request and converts the
// rasterizer's done level into a single frame-done pulse issued from IDLE,
// i.e. only after the last accepted pixel has retired.
module raster_pixel_writer
    import raster_pkg::*;
#(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int ADDR_W    = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    raster_pixel_writer_if.slave  bus
);

    localparam int                FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [15:0]          written_q, written_d;
    logic [15:0]          culled_q, culled_d;
    logic                 pending_q, pending_d;
    logic                 done_in_q, done_in_d;

    logic [ADDR_W-1:0]    gen_addr;
    logic                 on_screen;
    logic                 pixel_ready;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic [DEPTH_W-1:0]   mem_wr_depth;
    logic [COLOR_W-1:0]   mem_wr_color;
    logic                 frame_done;

    fb_addr_gen #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .x         (bus.in_pixel_x),
        .y         (bus.in_pixel_y),
        .addr      (gen_addr),
        .on_screen (on_screen)
    );

    // addr_q doubles as the clear sweep counter; it is also the memory
    // address in every state, which keeps the address at 0 after reset.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        depth_d      = depth_q;
        color_d      = color_q;
        written_d    = written_q;
        culled_d     = culled_q;
        done_in_d    = bus.in_sig_rasterize_done;
        pixel_ready  = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wr_depth = depth_q;
        mem_wr_color = color_q;
        frame_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pixel_ready = !bus.in_sig_clear;
                frame_done  = pending_q;
                if (bus.in_sig_clear) begin
                    state_d   = ST_CLEAR;
                    addr_d    = '0;
                    written_d = '0;
                    culled_d  = '0;
                end else if (bus.in_pixel_valid) begin
                    if (!on_screen) begin
                        culled_d = sat_inc(culled_q);
                    end else begin
                        addr_d  = gen_addr;
                        depth_d = bus.in_pixel_depth;
                        color_d = bus.in_pixel_color;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                state_d   = ST_TEST;
            end
            ST_TEST: begin
                // Stored depth arrives one cycle after the read strobe.
                if (depth_q <= bus.in_mem_depth_rdata) begin
                    mem_wr_en = 1'b1;
                    written_d = sat_inc(written_q);
                end else begin
                    culled_d = sat_inc(culled_q);
                end
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                mem_wr_en    = 1'b1;
                mem_wr_depth = DEPTH_FAR;
                mem_wr_color = bus.in_clear_color;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new rising edge wins over the clear caused by this cycle's pulse.
        pending_d = (pending_q && !frame_done) ||
                    (bus.in_sig_rasterize_done && !done_in_q);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            depth_q   <= '0;
            color_q   <= '0;
            written_q <= '0;
            culled_q  <= '0;
            pending_q <= 1'b0;
            done_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            depth_q   <= depth_d;
            color_q   <= color_d;
            written_q <= written_d;
            culled_q  <= culled_d;
            pending_q <= pending_d;
            done_in_q <= done_in_d;
        end
    end

    assign bus.out_pixel_ready    = pixel_ready;
    assign bus.out_sig_frame_done = frame_done;
    assign bus.out_mem_addr       = addr_q;
    assign bus.out_mem_rd_en      = mem_rd_en;
    assign bus.out_mem_wr_en      = mem_wr_en;
    assign bus.out_mem_wr_depth   = mem_wr_depth;
    assign bus.out_mem_wr_color   = mem_wr_color;
    assign bus.out_busy           = (state_q != ST_IDLE);
    assign bus.out_pixels_written = written_q;
    assign bus.out_pixels_culled  = culled_q;

endmodule
